// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search sequencer and its memory muxes.
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_LAUNCH_INIT = 4'd1,
        ST_RUN_INIT    = 4'd2,
        ST_LAUNCH_KSA  = 4'd3,
        ST_RUN_KSA     = 4'd4,
        ST_LAUNCH_PRGA = 4'd5,
        ST_RUN_PRGA    = 4'd6,
        ST_CHK_RD      = 4'd7,
        ST_CHK_WAIT    = 4'd8,
        ST_CHK_EVAL    = 4'd9,
        ST_NEXT_KEY    = 4'd10,
        ST_FOUND       = 4'd11,
        ST_FAIL        = 4'd12
    } ks_state_t;

    typedef enum logic [2:0] {
        GNT_NONE = 3'd0,
        GNT_INIT = 3'd1,
        GNT_KSA  = 3'd2,
        GNT_PRGA = 3'd3,
        GNT_CHK  = 3'd4
    } mem_grant_t;

    localparam int          MSG_LEN_DEFAULT = 32;
    localparam logic [23:0] KEY_MAX_DEFAULT = 24'h3FFFFF;
    localparam logic [7:0]  CHAR_SPACE      = 8'h20;
    localparam logic [7:0]  CHAR_A          = 8'h61;
    localparam logic [7:0]  CHAR_Z          = 8'h7A;

    function automatic logic is_printable(input logic [7:0] b);
        return (b == CHAR_SPACE) || ((b >= CHAR_A) && (b <= CHAR_Z));
    endfunction

    function automatic mem_grant_t s_grant_of(input ks_state_t s);
        case (s)
            ST_LAUNCH_INIT, ST_RUN_INIT: return GNT_INIT;
            ST_LAUNCH_KSA,  ST_RUN_KSA:  return GNT_KSA;
            ST_LAUNCH_PRGA, ST_RUN_PRGA: return GNT_PRGA;
            default:                     return GNT_NONE;
        endcase
    endfunction

    function automatic mem_grant_t d_grant_of(input ks_state_t s);
        case (s)
            ST_LAUNCH_PRGA, ST_RUN_PRGA:            return GNT_PRGA;
            ST_CHK_RD, ST_CHK_WAIT, ST_CHK_EVAL:    return GNT_CHK;
            default:                                return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rc4_mem_mux.sv
// Combinational single-port memory mux: slot i is served when grant == i+1 (init, ksa, prga, checker).
module rc4_mem_mux
    import rc4_pkg::*;
(
    input  logic [2:0]      grant,
    input  logic [3:0][7:0] req_address,
    input  logic [3:0][7:0] req_data_out,
    input  logic [3:0]      req_read_write,
    input  logic [3:0]      req_start_op,
    output logic [3:0]      req_finish_op,
    output logic [7:0]      mem_address,
    output logic [7:0]      mem_data_out,
    output logic            mem_read_write,
    output logic            mem_start_op,
    input  logic            mem_finish_op
);

    always_comb begin
        mem_address    = 8'h00;
        mem_data_out   = 8'h00;
        mem_read_write = 1'b0;
        mem_start_op   = 1'b0;
        req_finish_op  = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (grant == 3'(i + 1)) begin
                mem_address      = req_address[i];
                mem_data_out     = req_data_out[i];
                mem_read_write   = req_read_write[i];
                mem_start_op     = req_start_op[i];
                req_finish_op[i] = mem_finish_op;
            end
        end
    end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// RC4 key-search sequencer: runs init/KSA/PRGA per key, scans decrypted bytes, and owns the S/D memory muxes.
module rc4_key_search_ctrl
    import rc4_pkg::*;
#(
    parameter int          MSG_LEN = MSG_LEN_DEFAULT,
    parameter logic [23:0] KEY_MAX = KEY_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [23:0] key,
    output logic        done,
    output logic        found,
    output logic [3:0]  dbg_state,

    output logic        init_start,
    input  logic        init_finish,
    input  logic [7:0]  init_S_address,
    input  logic [7:0]  init_S_data_out,
    input  logic        init_S_readWrite,
    input  logic        init_S_start_op,
    output logic        init_S_finish_op,

    output logic        ksa_start,
    input  logic        ksa_finish,
    input  logic [7:0]  ksa_S_address,
    input  logic [7:0]  ksa_S_data_out,
    input  logic        ksa_S_readWrite,
    input  logic        ksa_S_start_op,
    output logic        ksa_S_finish_op,

    output logic        prga_start,
    input  logic        prga_finish,
    input  logic [7:0]  prga_S_address,
    input  logic [7:0]  prga_S_data_out,
    input  logic        prga_S_readWrite,
    input  logic        prga_S_start_op,
    output logic        prga_S_finish_op,

    output logic [7:0]  S_address,
    output logic [7:0]  S_data_out,
    output logic        S_readWrite,
    output logic        S_start_op,
    input  logic        S_finish_op,

    input  logic [7:0]  prga_D_address,
    input  logic [7:0]  prga_D_data_out,
    input  logic        prga_D_readWrite,
    input  logic        prga_D_start_op,
    output logic        prga_D_finish_op,

    output logic [7:0]  D_address,
    output logic [7:0]  D_data_out,
    output logic        D_readWrite,
    output logic        D_start_op,
    input  logic        D_finish_op,
    input  logic [7:0]  D_data_in
);

    localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

    ks_state_t   state_q;
    logic [23:0] key_q;
    logic [7:0]  k_q;
    logic [7:0]  byte_q;
    logic        init_start_q, ksa_start_q, prga_start_q;
    logic        done_q, found_q;
    logic        chk_start_q;
    logic [7:0]  chk_addr_q;

    logic [2:0]  s_grant, d_grant;
    logic [3:0]  s_fin, d_fin;
    logic        chk_finish;

    assign s_grant = s_grant_of(state_q);
    assign d_grant = d_grant_of(state_q);

    rc4_mem_mux u_s_mux (
        .grant          (s_grant),
        .req_address    ({8'h00, prga_S_address, ksa_S_address, init_S_address}),
        .req_data_out   ({8'h00, prga_S_data_out, ksa_S_data_out, init_S_data_out}),
        .req_read_write ({1'b0, prga_S_readWrite, ksa_S_readWrite, init_S_readWrite}),
        .req_start_op   ({1'b0, prga_S_start_op, ksa_S_start_op, init_S_start_op}),
        .req_finish_op  (s_fin),
        .mem_address    (S_address),
        .mem_data_out   (S_data_out),
        .mem_read_write (S_readWrite),
        .mem_start_op   (S_start_op),
        .mem_finish_op  (S_finish_op)
    );

    // The checker only reads, so its data-out and readWrite are tied low.
    rc4_mem_mux u_d_mux (
        .grant          (d_grant),
        .req_address    ({chk_addr_q, prga_D_address, 8'h00, 8'h00}),
        .req_data_out   ({8'h00, prga_D_data_out, 8'h00, 8'h00}),
        .req_read_write ({1'b0, prga_D_readWrite, 1'b0, 1'b0}),
        .req_start_op   ({chk_start_q, prga_D_start_op, 1'b0, 1'b0}),
        .req_finish_op  (d_fin),
        .mem_address    (D_address),
        .mem_data_out   (D_data_out),
        .mem_read_write (D_readWrite),
        .mem_start_op   (D_start_op),
        .mem_finish_op  (D_finish_op)
    );

    assign init_S_finish_op = s_fin[0];
    assign ksa_S_finish_op  = s_fin[1];
    assign prga_S_finish_op = s_fin[2];
    assign prga_D_finish_op = d_fin[2];
    assign chk_finish       = d_fin[3];

    logic unused_fin;
    assign unused_fin = ^{s_fin[3], d_fin[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            key_q        <= 24'h0;
            k_q          <= 8'h00;
            byte_q       <= 8'h00;
            init_start_q <= 1'b0;
            ksa_start_q  <= 1'b0;
            prga_start_q <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            chk_start_q  <= 1'b0;
            chk_addr_q   <= 8'h00;
        end else begin
            init_start_q <= 1'b0;
            ksa_start_q  <= 1'b0;
            prga_start_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FOUND, ST_FAIL: begin
                    if (start) begin
                        key_q   <= 24'h0;
                        done_q  <= 1'b0;
                        found_q <= 1'b0;
                        state_q <= ST_LAUNCH_INIT;
                    end
                end
                ST_LAUNCH_INIT: begin
                    init_start_q <= 1'b1;
                    state_q      <= ST_RUN_INIT;
                end
                ST_RUN_INIT: if (init_finish) state_q <= ST_LAUNCH_KSA;
                ST_LAUNCH_KSA: begin
                    ksa_start_q <= 1'b1;
                    state_q     <= ST_RUN_KSA;
                end
                ST_RUN_KSA: if (ksa_finish) state_q <= ST_LAUNCH_PRGA;
                ST_LAUNCH_PRGA: begin
                    prga_start_q <= 1'b1;
                    state_q      <= ST_RUN_PRGA;
                end
                ST_RUN_PRGA: begin
                    if (prga_finish) begin
                        k_q     <= 8'h00;
                        state_q <= ST_CHK_RD;
                    end
                end
                ST_CHK_RD: begin
                    chk_start_q <= 1'b1;
                    chk_addr_q  <= k_q;
                    state_q     <= ST_CHK_WAIT;
                end
                ST_CHK_WAIT: begin
                    if (chk_finish) begin
                        chk_start_q <= 1'b0;
                        byte_q      <= D_data_in;
                        state_q     <= ST_CHK_EVAL;
                    end
                end
                ST_CHK_EVAL: begin
                    if (!is_printable(byte_q)) begin
                        state_q <= ST_NEXT_KEY;
                    end else if (k_q == LAST_IDX) begin
                        done_q  <= 1'b1;
                        found_q <= 1'b1;
                        state_q <= ST_FOUND;
                    end else begin
                        k_q     <= k_q + 8'd1;
                        state_q <= ST_CHK_RD;
                    end
                end
                ST_NEXT_KEY: begin
                    // Compare before incrementing so key never wraps past KEY_MAX.
                    if (key_q == KEY_MAX) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FAIL;
                    end else begin
                        key_q   <= key_q + 24'd1;
                        state_q <= ST_LAUNCH_INIT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign key        = key_q;
    assign done       = done_q;
    assign found      = found_q;
    assign init_start = init_start_q;
    assign ksa_start  = ksa_start_q;
    assign prga_start = prga_start_q;
    assign dbg_state  = state_q;

endmodule
